// File: rtl/clock_divider_prog_if.sv
// Control/status bundle for the programmable clock-enable divider.
// The master side drives run/step/divisor; the slave (divider) returns tick, cout, count and halt status.
interface clock_divider_prog_if #(
    parameter int CNT_W  = 32,
    parameter int TCNT_W = 32
);
    logic              run;
    logic              step;
    logic [CNT_W-1:0]  div_val;
    logic              tick;
    logic              cout;
    logic [TCNT_W-1:0] tick_cnt;
    logic              halted;

    modport master (
        output run, step, div_val,
        input  tick, cout, tick_cnt, halted
    );

    modport slave (
        input  run, step, div_val,
        output tick, cout, tick_cnt, halted
    );
endinterface

// File: rtl/clock_divider_prog.sv
// Programmable divider producing a one-cycle tick enable and a 50% duty cout,
// with run/halt and single-step control for stepping the CPU clock during debug.
module clock_divider_prog #(
    parameter int CNT_W     = 32,
    parameter int TCNT_W    = 32,
    parameter int RESET_DIV = 0
) (
    input  logic                 cin,
    input  logic                 rst,
    clock_divider_prog_if.slave  bus
);

    // RESET_DIV only documents the usual divisor source; a negative value is meaningless.
    if (RESET_DIV < 0) begin : g_reset_div_negative
    end

    logic [CNT_W-1:0]  cnt_reg;
    logic [CNT_W-1:0]  div_cur_reg;
    logic [TCNT_W-1:0] tick_cnt_reg;
    logic              tick_reg;
    logic              cout_reg;
    logic              halted_reg;
    logic              step_q_reg;
    logic              pend_reg;

    logic              step_edge;
    logic              at_terminal;
    logic              fire;

    assign step_edge   = bus.step & ~step_q_reg;
    assign at_terminal = (cnt_reg == div_cur_reg);
    // Running: fire at terminal count. Halted: fire only on a pending step request.
    assign fire        = bus.run ? at_terminal : pend_reg;

    always_ff @(posedge cin) begin
        if (rst) begin
            cnt_reg      <= '0;
            div_cur_reg  <= bus.div_val;
            tick_cnt_reg <= '0;
            tick_reg     <= 1'b0;
            cout_reg     <= 1'b0;
            halted_reg   <= 1'b1;
            step_q_reg   <= 1'b1;
            pend_reg     <= 1'b0;
        end else begin
            step_q_reg <= bus.step;
            halted_reg <= ~bus.run;
            tick_reg   <= fire;
            // Edges seen while running are dropped, and run rising clears any pending step.
            pend_reg   <= ~bus.run & step_edge;

            if (fire) begin
                cnt_reg      <= '0;
                div_cur_reg  <= bus.div_val;
                cout_reg     <= ~cout_reg;
                tick_cnt_reg <= tick_cnt_reg + TCNT_W'(1);
            end else if (bus.run) begin
                cnt_reg <= cnt_reg + CNT_W'(1);
            end
        end
    end

    assign bus.tick     = tick_reg;
    assign bus.cout     = cout_reg;
    assign bus.tick_cnt = tick_cnt_reg;
    assign bus.halted   = halted_reg;

endmodule

// File: tb/tb_clock_divider_prog.sv
// Scenario bench for clock_divider_prog: expected tick cycles are queued as stimulus is
// applied and matched against every observed tick; counters and status are checked inline.
module tb_clock_divider_prog;

    localparam int CNT_W  = 8;
    localparam int TCNT_W = 4;

    logic cin = 1'b0;
    logic rst = 1'b1;

    clock_divider_prog_if #(.CNT_W(CNT_W), .TCNT_W(TCNT_W)) bus();

    clock_divider_prog #(.CNT_W(CNT_W), .TCNT_W(TCNT_W), .RESET_DIV(0)) dut (
        .cin (cin),
        .rst (rst),
        .bus (bus)
    );

    always #5 cin = ~cin;

    int cyc = 0;
    always @(posedge cin) cyc <= cyc + 1;

    int   total = 0;
    int   bad   = 0;
    int   exp_q[$];
    int   toggles;
    int   rst_cyc;
    logic last_cout;

    // Advance n cycles, sampling on the falling edge; each tick must match the head of the queue.
    task automatic step_cycles(input int n);
        int e;
        for (int i = 0; i < n; i++) begin
            @(negedge cin);
            if (bus.cout !== last_cout) toggles++;
            last_cout = bus.cout;
            if (bus.tick === 1'b1) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL tick_unexpected: tick seen at cycle %0d, required none", cyc);
                end else begin
                    e = exp_q.pop_front();
                    if (cyc !== e) begin
                        bad++;
                        $display("FAIL tick_time: tick seen at cycle %0d, required cycle %0d", cyc, e);
                    end
                end
            end
        end
    endtask

    task automatic run_until(input int c);
        step_cycles(c - cyc);
    endtask

    task automatic do_reset(input int div, input logic run_v, input logic step_v);
        @(negedge cin);
        rst         = 1'b1;
        bus.div_val = CNT_W'(div);
        bus.run     = run_v;
        bus.step    = step_v;
        @(negedge cin);
        rst     = 1'b0;
        rst_cyc = cyc;
        exp_q.delete();
        toggles   = 0;
        last_cout = bus.cout;
    endtask

    task automatic test_reset();
        do_reset(3, 1'b1, 1'b0);
        total++; if (bus.tick !== 1'b0) begin bad++; $display("FAIL reset_tick: got %b, required 0", bus.tick); end
        total++; if (bus.cout !== 1'b0) begin bad++; $display("FAIL reset_cout: got %b, required 0", bus.cout); end
        total++; if (bus.tick_cnt !== TCNT_W'(0)) begin bad++; $display("FAIL reset_tick_cnt: got %0d, required 0", bus.tick_cnt); end
        total++; if (bus.halted !== 1'b1) begin bad++; $display("FAIL reset_halted: got %b, required 1", bus.halted); end
        step_cycles(1);
        total++; if (bus.halted !== 1'b0) begin bad++; $display("FAIL halted_follow_run: got %b, required 0", bus.halted); end
    endtask

    task automatic test_run_div3();
        do_reset(3, 1'b1, 1'b0);
        for (int k = 0; k < 5; k++) exp_q.push_back(rst_cyc + 4 + 4 * k);
        run_until(rst_cyc + 20);
        total++; if (exp_q.size() != 0) begin bad++; $display("FAIL div3_missing: %0d ticks outstanding, required 0", exp_q.size()); end
        total++; if (bus.tick_cnt !== TCNT_W'(5)) begin bad++; $display("FAIL div3_tick_cnt: got %0d, required 5", bus.tick_cnt); end
        total++; if (toggles != 5) begin bad++; $display("FAIL div3_cout_toggles: got %0d, required 5", toggles); end
        total++; if (bus.cout !== 1'b1) begin bad++; $display("FAIL div3_cout: got %b, required 1", bus.cout); end
    endtask

    task automatic test_div0();
        do_reset(0, 1'b1, 1'b0);
        for (int k = 1; k <= 8; k++) exp_q.push_back(rst_cyc + k);
        run_until(rst_cyc + 8);
        total++; if (exp_q.size() != 0) begin bad++; $display("FAIL div0_missing: %0d ticks outstanding, required 0", exp_q.size()); end
        total++; if (bus.tick_cnt !== TCNT_W'(8)) begin bad++; $display("FAIL div0_tick_cnt: got %0d, required 8", bus.tick_cnt); end
        total++; if (toggles != 8) begin bad++; $display("FAIL div0_cout_toggles: got %0d, required 8", toggles); end
    endtask

    task automatic test_div_change();
        do_reset(9, 1'b1, 1'b0);
        exp_q.push_back(rst_cyc + 10);
        exp_q.push_back(rst_cyc + 13);
        exp_q.push_back(rst_cyc + 16);
        exp_q.push_back(rst_cyc + 19);
        run_until(rst_cyc + 4);
        bus.div_val = CNT_W'(2);
        run_until(rst_cyc + 19);
        total++; if (exp_q.size() != 0) begin bad++; $display("FAIL divchg_missing: %0d ticks outstanding, required 0", exp_q.size()); end
        total++; if (bus.tick_cnt !== TCNT_W'(4)) begin bad++; $display("FAIL divchg_tick_cnt: got %0d, required 4", bus.tick_cnt); end
    endtask

    task automatic test_halt();
        do_reset(9, 1'b1, 1'b0);
        exp_q.push_back(rst_cyc + 30);
        run_until(rst_cyc + 5);
        bus.run = 1'b0;
        toggles = 0;
        run_until(rst_cyc + 25);
        total++; if (toggles != 0) begin bad++; $display("FAIL halt_cout_stable: got %0d toggles, required 0", toggles); end
        total++; if (bus.halted !== 1'b1) begin bad++; $display("FAIL halt_halted: got %b, required 1", bus.halted); end
        total++; if (bus.tick_cnt !== TCNT_W'(0)) begin bad++; $display("FAIL halt_tick_cnt: got %0d, required 0", bus.tick_cnt); end
        bus.run = 1'b1;
        run_until(rst_cyc + 26);
        total++; if (bus.halted !== 1'b0) begin bad++; $display("FAIL resume_halted: got %b, required 0", bus.halted); end
        run_until(rst_cyc + 30);
        total++; if (exp_q.size() != 0) begin bad++; $display("FAIL resume_missing: %0d ticks outstanding, required 0", exp_q.size()); end
        total++; if (bus.tick_cnt !== TCNT_W'(1)) begin bad++; $display("FAIL resume_tick_cnt: got %0d, required 1", bus.tick_cnt); end
    endtask

    task automatic test_step();
        do_reset(9, 1'b0, 1'b0);
        step_cycles(3);
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(cyc + 2);
            bus.step = 1'b1;
            step_cycles(4);
            bus.step = 1'b0;
            step_cycles(4);
        end
        total++; if (exp_q.size() != 0) begin bad++; $display("FAIL step_missing: %0d ticks outstanding, required 0", exp_q.size()); end
        total++; if (bus.tick_cnt !== TCNT_W'(3)) begin bad++; $display("FAIL step_tick_cnt: got %0d, required 3", bus.tick_cnt); end
        total++; if (toggles != 3) begin bad++; $display("FAIL step_cout_toggles: got %0d, required 3", toggles); end
        // Edge while running must be ignored.
        bus.run  = 1'b1;
        bus.step = 1'b1;
        step_cycles(4);
        bus.step = 1'b0;
        bus.run  = 1'b0;
        step_cycles(2);
        // Pending step cancelled by run rising; held-high step then produces nothing.
        bus.step = 1'b1;
        step_cycles(1);
        bus.run = 1'b1;
        step_cycles(3);
        bus.run = 1'b0;
        step_cycles(4);
        bus.step = 1'b0;
        total++; if (bus.tick_cnt !== TCNT_W'(3)) begin bad++; $display("FAIL step_ignored_tick_cnt: got %0d, required 3", bus.tick_cnt); end
        total++; if (exp_q.size() != 0) begin bad++; $display("FAIL step_ignored_queue: %0d ticks outstanding, required 0", exp_q.size()); end
    endtask

    task automatic test_reset_mid();
        do_reset(5, 1'b1, 1'b0);
        exp_q.push_back(rst_cyc + 6);
        run_until(rst_cyc + 8);
        total++; if (bus.cout !== 1'b1) begin bad++; $display("FAIL midrst_pre_cout: got %b, required 1", bus.cout); end
        do_reset(5, 1'b0, 1'b1);
        total++; if (bus.tick !== 1'b0) begin bad++; $display("FAIL midrst_tick: got %b, required 0", bus.tick); end
        total++; if (bus.cout !== 1'b0) begin bad++; $display("FAIL midrst_cout: got %b, required 0", bus.cout); end
        total++; if (bus.tick_cnt !== TCNT_W'(0)) begin bad++; $display("FAIL midrst_tick_cnt: got %0d, required 0", bus.tick_cnt); end
        total++; if (bus.halted !== 1'b1) begin bad++; $display("FAIL midrst_halted: got %b, required 1", bus.halted); end
        step_cycles(5);
        bus.run = 1'b1;
        exp_q.push_back(cyc + 6);
        run_until(rst_cyc + 11);
        bus.step = 1'b0;
        total++; if (exp_q.size() != 0) begin bad++; $display("FAIL midrst_missing: %0d ticks outstanding, required 0", exp_q.size()); end
        total++; if (bus.tick_cnt !== TCNT_W'(1)) begin bad++; $display("FAIL midrst_after_tick_cnt: got %0d, required 1", bus.tick_cnt); end
    endtask

    task automatic test_wrap();
        do_reset(0, 1'b1, 1'b0);
        for (int k = 1; k <= 17; k++) exp_q.push_back(rst_cyc + k);
        run_until(rst_cyc + 15);
        total++; if (bus.tick_cnt !== TCNT_W'(15)) begin bad++; $display("FAIL wrap_max: got %0d, required 15", bus.tick_cnt); end
        step_cycles(1);
        total++; if (bus.tick_cnt !== TCNT_W'(0)) begin bad++; $display("FAIL wrap_zero: got %0d, required 0", bus.tick_cnt); end
        step_cycles(1);
        total++; if (bus.tick_cnt !== TCNT_W'(1)) begin bad++; $display("FAIL wrap_one: got %0d, required 1", bus.tick_cnt); end
        total++; if (exp_q.size() != 0) begin bad++; $display("FAIL wrap_missing: %0d ticks outstanding, required 0", exp_q.size()); end
    endtask

    initial begin
        bus.run     = 1'b0;
        bus.step    = 1'b0;
        bus.div_val = '0;
        last_cout   = 1'b0;
        toggles     = 0;
        rst_cyc     = 0;
        test_reset();
        test_run_div3();
        test_div0();
        test_div_change();
        test_halt();
        test_step();
        test_reset_mid();
        test_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
